// File: rtl/rr_arb_enc.sv
// Round-robin arbiter for 8 requesters with a binary-encoded grant that drives an external 3-to-8 decoder.
// Optional forced release after MAX_HOLD grant cycles is enabled by defining RR_ARB_TIMEOUT_EN.
module rr_arb_enc #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] req,
  input  logic       done,
  output logic       gnt_ena,
  output logic [2:0] gnt_idx,
  output logic       tmo
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("rr_arb_enc: MAX_HOLD must be within 2..255");
  end

  state_e     state_q, state_d;
  logic [2:0] gnt_idx_q, gnt_idx_d;
  logic [2:0] ptr_q, ptr_d;
  logic       tmo_q, tmo_d;

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
  logic [7:0] hold_q, hold_d;
`endif

  logic       pick_found;
  logic [2:0] pick_idx;
  logic [2:0] cand;

  // First set request bit scanning upward from ptr, wrapping modulo 8.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      cand = ptr_q + i[2:0];
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    gnt_idx_d = gnt_idx_q;
    ptr_d     = ptr_q;
    tmo_d     = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    hold_d    = hold_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d   = GRANT;
          gnt_idx_d = pick_idx;
`ifdef RR_ARB_TIMEOUT_EN
          hold_d    = '0;
`endif
        end
      end
      GRANT: begin
        if (done || !req[gnt_idx_q]) begin
          state_d = IDLE;
          ptr_d   = gnt_idx_q + 3'd1;
        end
`ifdef RR_ARB_TIMEOUT_EN
        // hold_q counts completed grant cycles minus one, so HOLD_LAST marks the last allowed cycle.
        else if (hold_q == HOLD_LAST) begin
          state_d = IDLE;
          ptr_d   = gnt_idx_q + 3'd1;
          tmo_d   = 1'b1;
        end else begin
          hold_d = hold_q + 8'd1;
        end
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_idx_q <= '0;
      ptr_q     <= '0;
      tmo_q     <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      gnt_idx_q <= gnt_idx_d;
      ptr_q     <= ptr_d;
      tmo_q     <= tmo_d;
`ifdef RR_ARB_TIMEOUT_EN
      hold_q    <= hold_d;
`endif
    end
  end

  assign gnt_ena = (state_q == GRANT);
  assign gnt_idx = gnt_idx_q;
  assign tmo     = tmo_q;

endmodule

// File: tb/tb_rr_arb_enc.sv
// Self-checking bench for rr_arb_enc: directed vector table, hand sequences for
// timeout/reset corners, and randomized traffic against a behavioural round-robin model.
module tb_rr_arb_enc;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] req;
  logic       done;
  logic       gnt_ena;
  logic [2:0] gnt_idx;
  logic       tmo;

  int checks   = 0;
  int failures = 0;

  rr_arb_enc #(.MAX_HOLD(MH)) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt_ena (gnt_ena),
    .gnt_idx (gnt_idx),
    .tmo     (tmo)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired before end of test");
    $fatal(1, "watchdog");
  end

  // Behavioural model: who owns the grant, how many grant cycles it has used, where the search starts.
  bit m_busy;
  int m_owner;
  int m_ptr;
  int m_cycles;
  bit m_tmo;

  task automatic model_reset();
    m_busy = 0; m_owner = 0; m_ptr = 0; m_cycles = 0; m_tmo = 0;
  endtask

  task automatic model_edge(input logic [7:0] r, input logic d);
    bit found;
    m_tmo = 0;
    if (!m_busy) begin
      found = 0;
      for (int k = 0; k < 8; k++) begin
        int n;
        n = (m_ptr + k) % 8;
        if (!found && r[n]) begin
          found = 1; m_busy = 1; m_owner = n; m_cycles = 1;
        end
      end
    end else if (d || !r[m_owner]) begin
      m_busy = 0; m_ptr = (m_owner + 1) % 8;
    end
`ifdef RR_ARB_TIMEOUT_EN
    else if (m_cycles == MH) begin
      m_busy = 0; m_ptr = (m_owner + 1) % 8; m_tmo = 1;
    end
`endif
    else begin
      m_cycles++;
    end
  endtask

  task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge(req, done);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req = '0; done = 1'b0;
    #1;
    model_reset();
    chk("reset_ena", {7'b0, gnt_ena}, 8'h00);
    chk("reset_idx", {5'b0, gnt_idx}, 8'h00);
    chk("reset_tmo", {7'b0, tmo}, 8'h00);
    @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct packed {
    logic [7:0] req;
    logic       done;
    logic       ena;
    logic [2:0] idx;
  } vec_t;

  vec_t vt [22];
  logic [7:0] dec;

  initial begin
    vt[0]  = '{8'h04, 1'b0, 1'b1, 3'd2};
    vt[1]  = '{8'h04, 1'b1, 1'b0, 3'd2};
    vt[2]  = '{8'h81, 1'b0, 1'b1, 3'd7};
    vt[3]  = '{8'h81, 1'b1, 1'b0, 3'd7};
    vt[4]  = '{8'h81, 1'b0, 1'b1, 3'd0};
    vt[5]  = '{8'h81, 1'b1, 1'b0, 3'd0};
    vt[6]  = '{8'h81, 1'b0, 1'b1, 3'd7};
    vt[7]  = '{8'h81, 1'b1, 1'b0, 3'd7};
    vt[8]  = '{8'h81, 1'b0, 1'b1, 3'd0};
    vt[9]  = '{8'h01, 1'b0, 1'b1, 3'd0};
    vt[10] = '{8'h00, 1'b0, 1'b0, 3'd0};
    vt[11] = '{8'h40, 1'b0, 1'b1, 3'd6};
    vt[12] = '{8'h41, 1'b1, 1'b0, 3'd6};
    vt[13] = '{8'h41, 1'b0, 1'b1, 3'd0};
    vt[14] = '{8'h41, 1'b1, 1'b0, 3'd0};
    vt[15] = '{8'h00, 1'b1, 1'b0, 3'd0};
    vt[16] = '{8'h10, 1'b0, 1'b1, 3'd4};
    vt[17] = '{8'hFF, 1'b0, 1'b1, 3'd4};
    vt[18] = '{8'hEF, 1'b0, 1'b0, 3'd4};
    vt[19] = '{8'hFF, 1'b0, 1'b1, 3'd5};
    vt[20] = '{8'hFF, 1'b1, 1'b0, 3'd5};
    vt[21] = '{8'hFF, 1'b0, 1'b1, 3'd6};

    rst = 1'b1; req = '0; done = 1'b0;

    // Directed vectors from reset.
    do_reset();
    for (int i = 0; i < 22; i++) begin
      req  = vt[i].req;
      done = vt[i].done;
      tick();
      chk($sformatf("vec%0d_ena", i), {7'b0, gnt_ena}, {7'b0, vt[i].ena});
      chk($sformatf("vec%0d_idx", i), {5'b0, gnt_idx}, {5'b0, vt[i].idx});
      chk($sformatf("vec%0d_tmo", i), {7'b0, tmo}, 8'h00);
      if (i == 0) begin
        dec = gnt_ena ? (8'h01 << gnt_idx) : 8'h00;
        chk("decoder_d", dec, 8'h04);
      end
    end

    // Held request with no done: forced release only in the timeout build.
    do_reset();
    req = 8'h08; done = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    for (int c = 1; c <= MH; c++) begin
      tick();
      chk($sformatf("hold%0d_ena", c), {7'b0, gnt_ena}, 8'h01);
      chk($sformatf("hold%0d_tmo", c), {7'b0, tmo}, 8'h00);
    end
    tick();
    chk("tmo_ena", {7'b0, gnt_ena}, 8'h00);
    chk("tmo_pulse", {7'b0, tmo}, 8'h01);
    chk("tmo_idx", {5'b0, gnt_idx}, 8'h03);
    tick();
    chk("regrant_ena", {7'b0, gnt_ena}, 8'h01);
    chk("regrant_idx", {5'b0, gnt_idx}, 8'h03);
    chk("regrant_tmo", {7'b0, tmo}, 8'h00);
`else
    for (int c = 1; c <= 10; c++) begin
      tick();
      chk($sformatf("hold%0d_ena", c), {7'b0, gnt_ena}, 8'h01);
      chk($sformatf("hold%0d_tmo", c), {7'b0, tmo}, 8'h00);
    end
`endif

    // done on the last allowed grant cycle is a normal release.
    do_reset();
    req = 8'h08; done = 1'b0;
    tick();
    for (int c = 1; c <= MH - 1; c++) begin
      tick();
      chk($sformatf("pre_done%0d_ena", c), {7'b0, gnt_ena}, 8'h01);
    end
    done = 1'b1;
    tick();
    chk("done_edge_ena", {7'b0, gnt_ena}, 8'h00);
    chk("done_edge_tmo", {7'b0, tmo}, 8'h00);
    done = 1'b0;
    tick();
    chk("after_done_tmo", {7'b0, tmo}, 8'h00);
    chk("after_done_idx", {5'b0, gnt_idx}, 8'h03);

    // Asynchronous reset in the middle of a grant to a non-zero index.
    do_reset();
    req = 8'hFF; done = 1'b0;
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    chk("pre_rst_idx", {5'b0, gnt_idx}, 8'h01);
    #3;
    rst = 1'b1;
    #1;
    model_reset();
    chk("async_rst_ena", {7'b0, gnt_ena}, 8'h00);
    chk("async_rst_idx", {5'b0, gnt_idx}, 8'h00);
    chk("async_rst_tmo", {7'b0, tmo}, 8'h00);
    @(negedge clk);
    rst = 1'b0; req = 8'hFF;
    tick();
    chk("post_rst_ena", {7'b0, gnt_ena}, 8'h01);
    chk("post_rst_idx", {5'b0, gnt_idx}, 8'h00);

    // Randomized traffic against the model; requests are sticky so grants often run long.
    do_reset();
    req = 8'($urandom);
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 7) == 0) req = 8'($urandom);
      done = ($urandom_range(0, 5) == 0);
      tick();
      chk("rand_ena", {7'b0, gnt_ena}, {7'b0, m_busy});
      chk("rand_idx", {5'b0, gnt_idx}, 8'(m_owner));
      chk("rand_tmo", {7'b0, tmo}, {7'b0, m_tmo});
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rr_arb_enc.md
RR_ARB_ENC -- requirements
Module: rr_arb_enc

Interface
REQ-001 Parameter: MAX_HOLD, 16, maximum consecutive grant cycles before forced release (legal 2..255).
REQ-002 Port: clk  input  1  sole clock; all state on rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: req  input  8  request vector; bit k = requester k.
REQ-005 Port: done  input  1  current grantee releases the grant.
REQ-006 Port: gnt_ena  output  1  grant active; drives the 3-to-8 decoder enable.
REQ-007 Port: gnt_idx  output  3  binary index of grantee; drives the decoder select.
REQ-008 Port: tmo  output  1  one-cycle pulse on forced (timeout) release.

Function
REQ-009 The block SHALL implement two states: IDLE (gnt_ena=0) and GRANT (gnt_ena=1); all outputs registered.
REQ-010 The block SHALL keep a 3-bit priority pointer ptr; search order ptr, ptr+1, ..., ptr+7, mod 8.
REQ-011 In IDLE with req nonzero, the block SHALL enter GRANT next edge with gnt_idx = first set req bit in search order; latency exactly 1 cycle.
REQ-012 In IDLE with req==0, the block SHALL stay in IDLE; done SHALL be ignored in IDLE.
REQ-013 In GRANT, gnt_idx SHALL remain constant; changes on other req bits SHALL have no effect.
REQ-014 In GRANT, release SHALL occur on the edge where done=1 or req[gnt_idx]=0 is sampled.
REQ-015 On any release, next state SHALL be IDLE for at least one cycle (gnt_ena=0 gap between grants) and ptr SHALL become gnt_idx+1 mod 8 (7 wraps to 0).
REQ-016 gnt_idx SHALL retain the last granted index while in IDLE.
REQ-017 A hold counter SHALL clear on GRANT entry and increment every GRANT cycle; width 8 bits, no wrap within legal MAX_HOLD.
REQ-018 With timeout compiled in, after gnt_ena has been high MAX_HOLD cycles without other release, the block SHALL release (REQ-015) and assert tmo for exactly the first IDLE cycle.
REQ-019 If done or req drop coincides with the timeout edge, the release SHALL be normal and tmo SHALL stay 0.
REQ-020 A requester holding req high after release SHALL be re-eligible but loses priority to any other pending requester per ptr.

Reset
REQ-021 rst=1 SHALL immediately, without clock, force state=IDLE, gnt_ena=0, gnt_idx=0, tmo=0, ptr=0, hold counter=0.
REQ-022 Reset asserted mid-grant SHALL drop gnt_ena in the same cycle; after deassertion the first grant SHALL search from index 0.
REQ-023 Outputs SHALL not change on the first clock edge coinciding with rst deassertion beyond IDLE evaluation of req.

Configuration
REQ-024 Macro RR_ARB_TIMEOUT_EN defined: REQ-017..REQ-019 active.
REQ-025 Macro RR_ARB_TIMEOUT_EN undefined: no hold counter, grant held until done or req drop indefinitely, tmo tied to 0; MAX_HOLD ignored.

Verification
REQ-026 Reset, req=8'b0000_0100 -> after 1 cycle gnt_ena=1, gnt_idx=2; decoder d=8'b0000_0100.
REQ-027 req=8'b1000_0001 held, done pulsed each grant -> gnt_idx sequence 0,7,0,7 with one gnt_ena=0 cycle between grants.
REQ-028 ptr=7 after grant to 6, req=8'b0100_0001 -> grant to 0 (wrap), not 6.
REQ-029 Timeout build, MAX_HOLD=4, req[3] held, no done -> gnt_ena high exactly 4 cycles, then tmo=1 for 1 cycle with gnt_ena=0; non-timeout build: gnt_ena stays high, tmo=0.
REQ-030 Timeout build, done=1 on 4th grant cycle -> release, tmo=0.
REQ-031 rst asserted mid-grant between clock edges -> gnt_ena=0, gnt_idx=0 immediately; after release req=8'hFF -> first grant gnt_idx=0.
